// File: rtl/gfsk_tx_frame_sequencer_pkg.sv
// Shared types and constants for the GFSK transmit frame sequencer.
package gfsk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SYNC,
    ST_PAYLOAD,
    ST_FLUSH
  } state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [15:0] DEF_SYNC_WORD = 16'hD391;

  // Bytes ride in the upper half of the 16-bit MSB-first shifter.
  function automatic logic [15:0] msb_align(input logic [7:0] b);
    return {b, 8'h00};
  endfunction

endpackage

// File: rtl/gfsk_tx_frame_sequencer_if.sv
// Payload byte stream from the packet buffer / MAC into the frame sequencer.
interface gfsk_tx_frame_sequencer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;

  modport master (output in_data, in_valid, in_last, input in_ready);
  modport slave  (input in_data, in_valid, in_last, output in_ready);
endinterface

// File: rtl/gfsk_tx_frame_sequencer_bit_serializer.sv
// Oversampling bit serializer: holds each MSB of a 16-bit shifter for SPS clocks.
module gfsk_bit_serializer #(
  parameter int SPS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run_i,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [15:0] data_i,
  output logic        sym_end_o,
  output logic        bit_o
);

  localparam int CW = (SPS > 1) ? $clog2(SPS) : 1;

  logic [CW-1:0] cnt_q;
  logic [15:0]   sr_q;

  assign sym_end_o = run_i && (cnt_q == CW'(SPS - 1));
  assign bit_o     = sr_q[15];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
      sr_q  <= data_i;
    end else if (sym_end_o) begin
      cnt_q <= '0;
      sr_q  <= {sr_q[14:0], 1'b0};
    end else if (run_i) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/gfsk_tx_frame_sequencer.sv
// Frame sequencer feeding the Gaussian filter: preamble, sync word, payload, flush.
module gfsk_tx_frame_sequencer
  import gfsk_pkg::*;
#(
  parameter int          SPS            = 8,
  parameter int          PREAMBLE_BYTES = 4,
  parameter logic [15:0] SYNC_WORD      = DEF_SYNC_WORD,
  parameter int          FLUSH_CYCLES   = 5
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        abort,
  gfsk_tx_frame_sequencer_if.slave    s_if,
  output logic                        tx_bit,
  output logic                        tx_active,
  output logic                        done,
  output logic                        underrun
);

  localparam int BCW = (PREAMBLE_BYTES > 0) ? $clog2(PREAMBLE_BYTES + 1) : 1;
  localparam int FCW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  state_e         state_q;
  logic [3:0]     bit_idx_q;
  logic [BCW-1:0] byte_cnt_q;
  logic [FCW-1:0] flush_cnt_q;
  logic           last_q, und_pend_q;
  logic           tx_active_q, done_q, underrun_q;

  logic        sym_end, ser_bit;
  logic        live, start_ok, kill, byte_end, slot, ready, accept;
  logic        ser_load, ser_clear;
  logic [15:0] ser_data;

  always_comb begin
    live     = (state_q == ST_PREAMBLE) || (state_q == ST_SYNC) || (state_q == ST_PAYLOAD);
    start_ok = (state_q == ST_IDLE) && start && !done_q;
    kill     = live && abort;
    byte_end = sym_end && (bit_idx_q == 4'd7);
    // Byte slot: end of the last sync symbol, or end of a non-final payload byte.
    slot     = sym_end && (((state_q == ST_SYNC) && (bit_idx_q == 4'd15)) ||
                           ((state_q == ST_PAYLOAD) && (bit_idx_q == 4'd7) && !last_q));
    ready    = slot && !abort;
    accept   = ready && s_if.in_valid;

    ser_load  = 1'b0;
    ser_clear = 1'b0;
    ser_data  = msb_align(PREAMBLE_BYTE);
    if (start_ok) begin
      ser_load = 1'b1;
    end else if (kill) begin
      ser_clear = 1'b1;
    end else if ((state_q == ST_PREAMBLE) && byte_end) begin
      ser_load = 1'b1;
      if (byte_cnt_q == BCW'(PREAMBLE_BYTES - 1)) ser_data = SYNC_WORD;
    end else if (slot) begin
      if (accept) begin
        ser_load = 1'b1;
        ser_data = msb_align(s_if.in_data);
      end else begin
        ser_clear = 1'b1;
      end
    end else if ((state_q == ST_PAYLOAD) && byte_end) begin
      ser_clear = 1'b1;
    end
  end

  assign s_if.in_ready = ready;

  gfsk_bit_serializer #(.SPS(SPS)) u_ser (
    .clk       (clk),
    .reset_n   (reset_n),
    .run_i     (live),
    .load_i    (ser_load),
    .clear_i   (ser_clear),
    .data_i    (ser_data),
    .sym_end_o (sym_end),
    .bit_o     (ser_bit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      bit_idx_q   <= '0;
      byte_cnt_q  <= '0;
      flush_cnt_q <= '0;
      last_q      <= 1'b0;
      und_pend_q  <= 1'b0;
      tx_active_q <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      if (kill) begin
        state_q     <= ST_FLUSH;
        flush_cnt_q <= '0;
        und_pend_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: if (start_ok) begin
            state_q     <= ST_PREAMBLE;
            tx_active_q <= 1'b1;
            bit_idx_q   <= '0;
            byte_cnt_q  <= '0;
            last_q      <= 1'b0;
            und_pend_q  <= 1'b0;
          end
          ST_PREAMBLE: begin
            if (byte_end) begin
              bit_idx_q <= '0;
              if (byte_cnt_q == BCW'(PREAMBLE_BYTES - 1)) state_q <= ST_SYNC;
              else byte_cnt_q <= byte_cnt_q + BCW'(1);
            end else if (sym_end) begin
              bit_idx_q <= bit_idx_q + 4'd1;
            end
          end
          ST_SYNC, ST_PAYLOAD: begin
            if (slot) begin
              if (accept) begin
                state_q   <= ST_PAYLOAD;
                bit_idx_q <= '0;
                last_q    <= s_if.in_last;
              end else begin
                state_q     <= ST_FLUSH;
                flush_cnt_q <= '0;
                und_pend_q  <= 1'b1;
              end
            end else if ((state_q == ST_PAYLOAD) && byte_end) begin
              state_q     <= ST_FLUSH;
              flush_cnt_q <= '0;
            end else if (sym_end) begin
              bit_idx_q <= bit_idx_q + 4'd1;
            end
          end
          ST_FLUSH: begin
            if (flush_cnt_q == FCW'(FLUSH_CYCLES - 1)) begin
              state_q     <= ST_IDLE;
              tx_active_q <= 1'b0;
              done_q      <= 1'b1;
              underrun_q  <= und_pend_q;
              und_pend_q  <= 1'b0;
            end else begin
              flush_cnt_q <= flush_cnt_q + FCW'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign tx_bit    = ser_bit;
  assign tx_active = tx_active_q;
  assign done      = done_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_gfsk_tx_frame_sequencer.sv
// Directed bench with a per-clock expected-bit scoreboard for two sequencer configs.
module tb_gfsk_tx_frame_sequencer;
  import gfsk_pkg::*;

  localparam int          PRE = 4;
  localparam int          F   = 5;
  localparam logic [15:0] SW  = 16'hD391;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, start, abort, sel;
  logic [7:0] d;
  logic       v, l;
  logic       bit_a, act_a, done_a, und_a;
  logic       bit_b, act_b, done_b, und_b;
  logic       start_a, start_b, abort_a, abort_b;

  gfsk_tx_frame_sequencer_if ifa ();
  gfsk_tx_frame_sequencer_if ifb ();
  assign ifa.in_data = d;  assign ifa.in_valid = v;  assign ifa.in_last = l;
  assign ifb.in_data = d;  assign ifb.in_valid = v;  assign ifb.in_last = l;
  assign start_a = start & ~sel;  assign abort_a = abort & ~sel;
  assign start_b = start & sel;   assign abort_b = abort & sel;

  gfsk_tx_frame_sequencer #(.SPS(8), .PREAMBLE_BYTES(PRE), .SYNC_WORD(SW), .FLUSH_CYCLES(F)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .abort(abort_a), .s_if(ifa),
    .tx_bit(bit_a), .tx_active(act_a), .done(done_a), .underrun(und_a));

  gfsk_tx_frame_sequencer #(.SPS(2), .PREAMBLE_BYTES(PRE), .SYNC_WORD(SW), .FLUSH_CYCLES(F)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .abort(abort_b), .s_if(ifb),
    .tx_bit(bit_b), .tx_active(act_b), .done(done_b), .underrun(und_b));

  logic m_bit, m_act, m_done, m_und, m_rdy;
  assign m_bit  = sel ? bit_b  : bit_a;
  assign m_act  = sel ? act_b  : act_a;
  assign m_done = sel ? done_b : done_a;
  assign m_und  = sel ? und_b  : und_a;
  assign m_rdy  = sel ? ifb.in_ready : ifa.in_ready;

  int checks = 0, errors = 0;
  int act_cnt, done_cnt, und_cnt, rdy_cnt, exp_len, sps;
  bit exp_q[$];
  logic [7:0] bytes_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor samples mid-low-phase so driver changes at negedge have settled.
  always @(negedge clk) begin
    #2;
    if (reset_n && m_act) begin
      act_cnt++;
      if (exp_q.size() == 0) chk("tx_bit_extra", 32'(act_cnt), 32'(exp_len));
      else chk("tx_bit", 32'(m_bit), 32'(exp_q.pop_front()));
    end
    if (m_done) done_cnt++;
    if (m_und)  und_cnt++;
    if (m_rdy)  rdy_cnt++;
  end

  task automatic reset_counters();
    act_cnt = 0; done_cnt = 0; und_cnt = 0; rdy_cnt = 0;
    exp_q.delete();
  endtask

  task automatic build_exp(input int n_send, input int trunc);
    bit s[$];
    for (int i = 0; i < PRE * 8; i++) repeat (sps) s.push_back(i[0]);
    for (int i = 15; i >= 0; i--) repeat (sps) s.push_back(SW[i]);
    for (int b = 0; b < n_send; b++)
      for (int k = 7; k >= 0; k--) repeat (sps) s.push_back(bytes_q[b][k]);
    if (trunc >= 0) while (s.size() > trunc + 1) void'(s.pop_back());
    repeat (F) s.push_back(1'b0);
    exp_q   = s;
    exp_len = s.size();
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_rdy(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (m_rdy) begin ok = 1'b1; return; end
      @(negedge clk);
    end
    chk("rdy_timeout", 32'(ok), 32'd1);
  endtask

  task automatic feed(input int n_send, input bit poke);
    bit ok;
    for (int i = 0; i < bytes_q.size(); i++) begin
      if (i < n_send) begin
        v = 1'b1; d = bytes_q[i]; l = (i == bytes_q.size() - 1);
      end else v = 1'b0;
      if (poke && i == 1) begin start = 1'b1; @(negedge clk); start = 1'b0; end
      wait_rdy(ok);
      if (!ok) break;
      @(negedge clk);
      v = 1'b0; l = 1'b0;
      if (i >= n_send) break;
    end
  endtask

  task automatic wait_done(input bit exp_und, input bit poke);
    bit seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      if (m_done) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("underrun_with_done", 32'(m_und), 32'(exp_und));
      chk("tx_active_at_done", 32'(m_act), 32'd0);
      if (poke) begin start = 1'b1; @(negedge clk); start = 1'b0; end
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic frame_checks(input int len, input int und, input int rdy);
    chk("active_len", 32'(act_cnt), 32'(len));
    chk("exp_left", 32'(exp_q.size()), 32'd0);
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("underrun_count", 32'(und_cnt), 32'(und));
    chk("ready_count", 32'(rdy_cnt), 32'(rdy));
    chk("idle_after", 32'(m_act), 32'd0);
  endtask

  task automatic run_frame(input int n_send, input bit exp_und, input int exp_rdy, input bit poke);
    reset_counters();
    build_exp(n_send, -1);
    pulse_start();
    feed(n_send, poke);
    wait_done(exp_und, poke);
    frame_checks(exp_len, exp_und, exp_rdy);
  endtask

  task automatic run_abort(input int c);
    reset_counters();
    bytes_q = '{8'h77};
    build_exp(0, c);
    v = 1'b1; d = 8'h77; l = 1'b1;
    pulse_start();
    repeat (c) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; v = 1'b0; l = 1'b0;
    wait_done(1'b0, 1'b0);
    frame_checks(c + 1 + F, 0, 0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; sel = 1'b0;
    d = '0; v = 1'b0; l = 1'b0; sps = 8;
    reset_counters();
    repeat (3) @(negedge clk);
    chk("rst_tx_bit", 32'(bit_a), 32'd0);
    chk("rst_tx_active", 32'(act_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_underrun", 32'(und_a), 32'd0);
    chk("rst_in_ready", 32'(ifa.in_ready), 32'd0);
    chk("rst_b_tx_active", 32'(act_b), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two-byte frame; stray starts mid-payload and on the done cycle.
    bytes_q = '{8'hA5, 8'h3C};
    run_frame(2, 1'b0, 2, 1'b1);
    chk("len_formula_2B", 32'(exp_len), 32'((PRE * 8 + 16 + 16) * 8 + F));

    // Second byte missing at its slot.
    bytes_q = '{8'hA5, 8'h3C};
    run_frame(1, 1'b1, 2, 1'b0);
    chk("len_underrun", 32'(exp_len), 32'((PRE * 8 + 16 + 8) * 8 + F));

    // Abort in sync bit 5, then abort colliding with the byte slot.
    run_abort((PRE * 8 + 5) * 8 + 3);
    run_abort((PRE * 8 + 16) * 8 - 1);

    // Reset mid-payload.
    reset_counters();
    bytes_q = '{8'hA5, 8'h3C};
    build_exp(2, -1);
    pulse_start();
    begin
      bit ok;
      v = 1'b1; d = 8'hA5; l = 1'b0;
      wait_rdy(ok);
      @(negedge clk);
      v = 1'b0;
    end
    repeat (10) @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_tx_bit", 32'(m_bit), 32'd0);
    chk("mid_rst_tx_active", 32'(m_act), 32'd0);
    chk("mid_rst_done", 32'(m_done), 32'd0);
    chk("mid_rst_underrun", 32'(m_und), 32'd0);
    chk("mid_rst_in_ready", 32'(m_rdy), 32'd0);
    repeat (2) @(negedge clk);
    chk("mid_rst_no_done", 32'(done_cnt), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(2, 1'b0, 2, 1'b0);

    // SPS=2 instance, single 0xFF byte.
    sel = 1'b1; sps = 2;
    repeat (2) @(negedge clk);
    bytes_q = '{8'hFF};
    run_frame(1, 1'b0, 1, 1'b0);
    chk("len_sps2", 32'(exp_len), 32'((PRE * 8 + 16 + 8) * 2 + F));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
